bus_arbiter: RTL and testbench

- Owns the shared L2/memory coherence bus: keeps the global 8-beat bus slot counter and grants each slot to one of NREQ transmitters.
- Transmitters include l2 bus transmitters and the memory controller.
- Multiplexes the winning transmitter's cmd/tag/addr/data onto the broadcast bus for the 8 cycles of its slot.
- Round-robin fairness; optional fixed priority for requester 0.

---
 rtl/bus_arbiter_pkg.sv | 27 ++
 rtl/rr_pick.sv | 32 +++
 rtl/bus_arbiter.sv | 104 ++++++++++
 tb/tb_bus_arbiter.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// Shared coherence-bus definitions: command encodings, requester IDs, slot timing
// and the per-requester slot payload.
package bus_arbiter_pkg;

  localparam int         SLOT_LEN  = 8;
  localparam logic [2:0] LAST_BEAT = 3'(SLOT_LEN - 1);

  localparam logic [2:0] CMD_NOP     = 3'd0;
  localparam logic [2:0] CMD_BUSRD   = 3'd1;
  localparam logic [2:0] CMD_BUSRDX  = 3'd2;
  localparam logic [2:0] CMD_BUSUPGR = 3'd3;
  localparam logic [2:0] CMD_FLUSH   = 3'd4;
  localparam logic [2:0] CMD_WB      = 3'd5;

  localparam int BUSID_MEM  = 0;
  localparam int BUSID_L2_0 = 1;
  localparam int BUSID_L2_1 = 2;
  localparam int BUSID_L2_2 = 3;

  typedef struct packed {
    logic [2:0]  cmd;
    logic [4:0]  tag;
    logic [25:0] addr;
    logic [63:0] data;
  } bus_beat_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, modulo N.
// Wrap is by explicit compare so non-power-of-two N works.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Coherence-bus slot arbiter: 8-beat slot counter, cycle-7 grant, owner mux.
// Define BUS_ARB_PRIO0_EN to give requester 0 absolute priority.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_bus_req,
  input  logic [3*NREQ-1:0]    req_bus_cmd,
  input  logic [5*NREQ-1:0]    req_bus_tag,
  input  logic [26*NREQ-1:0]   req_bus_addr,
  input  logic [64*NREQ-1:0]   req_bus_data,
  output logic [NREQ-1:0]      bus_grant,
  output logic [2:0]           bus_cycle,
  output logic                 bus_valid,
  output logic [IDW-1:0]       bus_owner,
  output logic [2:0]           bus_cmd,
  output logic [4:0]           bus_tag,
  output logic [25:0]          bus_addr,
  output logic [63:0]          bus_data
);

  logic                 owner_valid;
  logic [IDW-1:0]       owner, ptr;
  logic                 last;
  logic [NREQ-1:0]      rr_req, rr_gnt, win_gnt;
  logic [IDW-1:0]       rr_idx, win_idx;
  logic                 rr_any, win_any, upd_ptr;
  bus_beat_t [NREQ-1:0] slot_in;
  bus_beat_t            sel;

  assign last = (bus_cycle == LAST_BEAT);

`ifdef BUS_ARB_PRIO0_EN
  // Requester 0 bypasses rotation; the rest rotate with bit 0 masked out.
  assign rr_req = {req_bus_req[NREQ-1:1], 1'b0};

  always_comb begin
    win_gnt = rr_gnt;
    win_idx = rr_idx;
    win_any = rr_any;
    upd_ptr = rr_any;
    if (req_bus_req[0]) begin
      win_gnt = {{(NREQ-1){1'b0}}, 1'b1};
      win_idx = '0;
      win_any = 1'b1;
      upd_ptr = 1'b0;
    end
  end
`else
  assign rr_req  = req_bus_req;
  assign win_gnt = rr_gnt;
  assign win_idx = rr_idx;
  assign win_any = rr_any;
  assign upd_ptr = rr_any;
`endif

  rr_pick #(.N(NREQ), .IW(IDW)) u_pick (
    .req (rr_req),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx),
    .any (rr_any)
  );

  assign bus_grant = last ? win_gnt : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus_cycle   <= '0;
      owner_valid <= 1'b0;
      owner       <= '0;
      ptr         <= '0;
    end else begin
      bus_cycle <= last ? 3'd0 : bus_cycle + 3'd1;
      if (last) begin
        owner_valid <= win_any;
        if (win_any) owner <= win_idx;
        if (upd_ptr) ptr <= (win_idx == IDW'(NREQ-1)) ? '0 : win_idx + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign slot_in[i] = '{cmd:  req_bus_cmd[3*i +: 3],
                          tag:  req_bus_tag[5*i +: 5],
                          addr: req_bus_addr[26*i +: 26],
                          data: req_bus_data[64*i +: 64]};
  end

  // Only the owner is registered; the beat data is taken live from its slice.
  assign sel = owner_valid ? slot_in[owner] : '0;

  assign bus_valid = owner_valid;
  assign bus_owner = owner;
  assign bus_cmd   = sel.cmd;
  assign bus_tag   = sel.tag;
  assign bus_addr  = sel.addr;
  assign bus_data  = sel.data;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the bus outputs.
module tb_bus_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [3:0]       req = '0;
  logic [3:0][2:0]  cmd_a  = {3'b110, 3'b010, 3'b011, 3'b101};
  logic [3:0][4:0]  tag_a  = {5'h13, 5'h0a, 5'h11, 5'h10};
  logic [3:0][25:0] addr_a = {26'h3000003, 26'h0123456, 26'h1000001, 26'h0abcdef};
  logic [3:0][63:0] data_a;
  logic [2:0]       tb_beat = 3'd0;
  logic             own_known = 1'b1;

  logic [3:0]  bus_grant;
  logic [2:0]  bus_cycle;
  logic        bus_valid;
  logic [1:0]  bus_owner;
  logic [2:0]  bus_cmd;
  logic [4:0]  bus_tag;
  logic [25:0] bus_addr;
  logic [63:0] bus_data;

  typedef struct {
    logic [3:0]  gnt;
    logic [2:0]  cyc;
    logic        vld;
    logic        own_chk;
    logic [1:0]  own;
    logic [2:0]  cmd;
    logic [4:0]  tag;
    logic [25:0] addr;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [63:0] pat(input int i, input logic [2:0] b);
    return 64'hd0d0_0000_0000_0000 | (64'(i) << 16) | 64'(b);
  endfunction

  always_comb begin
    data_a = '0;
    for (int i = 0; i < 4; i++) data_a[i] = pat(i, tb_beat);
  end

  bus_arbiter #(.NREQ(4), .IDW(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_bus_req  (req),
    .req_bus_cmd  (cmd_a),
    .req_bus_tag  (tag_a),
    .req_bus_addr (addr_a),
    .req_bus_data (data_a),
    .bus_grant    (bus_grant),
    .bus_cycle    (bus_cycle),
    .bus_valid    (bus_valid),
    .bus_owner    (bus_owner),
    .bus_cmd      (bus_cmd),
    .bus_tag      (bus_tag),
    .bus_addr     (bus_addr),
    .bus_data     (bus_data)
  );

  task automatic cmp(input string nm, input logic [2:0] b,
                     input logic [63:0] act, input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s beat %0d: got %0h, want %0h", nm, b, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      cmp("cycle", mon_e.cyc, 64'(bus_cycle), 64'(mon_e.cyc));
      cmp("grant", mon_e.cyc, 64'(bus_grant), 64'(mon_e.gnt));
      cmp("valid", mon_e.cyc, 64'(bus_valid), 64'(mon_e.vld));
      if (mon_e.own_chk) cmp("owner", mon_e.cyc, 64'(bus_owner), 64'(mon_e.own));
      cmp("cmd",  mon_e.cyc, 64'(bus_cmd),  64'(mon_e.cmd));
      cmp("tag",  mon_e.cyc, 64'(bus_tag),  64'(mon_e.tag));
      cmp("addr", mon_e.cyc, 64'(bus_addr), 64'(mon_e.addr));
      cmp("data", mon_e.cyc, bus_data,      mon_e.data);
    end
  end

  // Push the expectation for the current cycle, then advance one clock.
  task automatic chk(input logic [3:0] g, input logic v, input logic [1:0] o);
    exp_t e;
    logic r;
    e.gnt     = g;
    e.cyc     = tb_beat;
    e.vld     = v;
    e.own_chk = v | own_known;
    e.own     = o;
    e.cmd     = v ? cmd_a[o]  : '0;
    e.tag     = v ? tag_a[o]  : '0;
    e.addr    = v ? addr_a[o] : '0;
    e.data    = v ? pat(int'(o), tb_beat) : '0;
    q.push_back(e);
    r = rst;
    @(posedge clk);
    #1;
    tb_beat = r ? 3'd0 : tb_beat + 3'd1;
  endtask

  task automatic run_slot(input logic [3:0] reqv, input logic [3:0] g7,
                          input logic v, input logic [1:0] o);
    for (int b = 0; b < 8; b++) begin
      req = reqv;
      chk((b == 7) ? g7 : 4'b0000, v, o);
    end
  endtask

`ifdef BUS_ARB_PRIO0_EN
  logic [4:0][3:0] t3_g = {4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
  logic [4:0][1:0] t3_o = {2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
  logic [1:0]      rs_own = 2'd0;
  logic [3:0]      pr_req = 4'b1110;
  logic [3:0][3:0] pr_g = {4'b0010, 4'b1000, 4'b0100, 4'b0010};
  logic [3:0][1:0] pr_o = {2'd3, 2'd2, 2'd1, 2'd0};
`else
  logic [4:0][3:0] t3_g = {4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
  logic [4:0][1:0] t3_o = {2'd2, 2'd1, 2'd0, 2'd3, 2'd0};
  logic [1:0]      rs_own = 2'd3;
  logic [3:0]      pr_req = 4'b1111;
  logic [3:0][3:0] pr_g = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0][1:0] pr_o = {2'd2, 2'd1, 2'd0, 2'd0};
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    tb_beat = 3'd0;

    // Idle after reset: counter runs, nothing granted, owner stays 0.
    own_known = 1'b1;
    run_slot(4'b0000, 4'b0000, 1'b0, 2'd0);
    run_slot(4'b0000, 4'b0000, 1'b0, 2'd0);
    own_known = 1'b0;

    // Requester 2 raises req at beat 3, wins at beat 7, owns the next slot.
    for (int b = 0; b < 8; b++) begin
      if (b == 3) req = 4'b0100;
      chk((b == 7) ? 4'b0100 : 4'b0000, 1'b0, 2'd0);
    end
    run_slot(4'b0000, 4'b0000, 1'b1, 2'd2);

    // Requester 1 pulses in beats 2..4 only: no grant, pointer untouched.
    for (int b = 0; b < 8; b++) begin
      req = (b >= 2 && b < 5) ? 4'b0010 : 4'b0000;
      chk(4'b0000, 1'b0, 2'd0);
    end
    run_slot(4'b0000, 4'b0000, 1'b0, 2'd0);

    // All requesting; first grant reveals the pointer left by requester 2.
    for (int s = 0; s < 5; s++) run_slot(4'b1111, t3_g[s], (s != 0), t3_o[s]);

    // Reset lands at beat 4 of an owned slot.
    for (int b = 0; b < 5; b++) begin
      req = 4'b1111;
      if (b == 4) rst = 1'b1;
      chk(4'b0000, 1'b1, rs_own);
    end
    rst = 1'b0;

    own_known = 1'b1;
    run_slot(pr_req, pr_g[0], 1'b0, pr_o[0]);
    own_known = 1'b0;
    for (int s = 1; s < 4; s++) run_slot(pr_req, pr_g[s], 1'b1, pr_o[s]);

    req = 4'b0000;
    @(negedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "timeout");
  end

endmodule
